acc_clmul_responder: RTL

Carry-less multiply accelerator sitting on the accelerator side of the `acc_c` offload interface, as one of the `acc_c_mst_req_o`/`acc_c_mst_rsp_i` ports of `acc_interconnect`. It accepts offloaded RV32 Zbc instructions (`clmul`, `clmulh`, `clmulr`) through the q valid/ready channel and computes them iteratively, `BitsPerCycle` bits per cycle. It returns the result and destination register through the p valid/ready channel. One instruction is in flight at a time.

---
 rtl/acc_clmul_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/acc_clmul_responder.sv
// acc_clmul_responder
//   Carry-less multiply accelerator on the acc_c offload interface. It accepts
//   one RV32 Zbc instruction (clmul, clmulh or clmulr) at a time on the q
//   channel. The product is built iteratively, BitsPerCycle bits of rs2 per
//   cycle, and the result is returned on the p channel.
//
//   Optional feature macro: ACC_CLMUL_EARLY_EXIT_EN
//     When defined, BUSY ends as soon as the remaining rs2 bits are all zero.
//     Results are unchanged; only latency differs.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   q_valid_i/q_ready_o request handshake
//   q_instr_data_i      offloaded instruction word
//   q_rs1_i, q_rs2_i    operands
//   q_rs3_i             unused operand
//   p_valid_o/p_ready_i response handshake
//   p_rd_o, p_data_o    destination register and result
module acc_clmul_responder #(
  parameter int unsigned BitsPerCycle = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        q_valid_i,
  output logic        q_ready_o,
  input  logic [31:0] q_instr_data_i,
  input  logic [31:0] q_rs1_i,
  input  logic [31:0] q_rs2_i,
  input  logic [31:0] q_rs3_i,
  output logic        p_valid_o,
  input  logic        p_ready_i,
  output logic [4:0]  p_rd_o,
  output logic [31:0] p_data_o
);

  localparam int unsigned N    = 32 / BitsPerCycle;
  localparam logic [4:0]  LAST = 5'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q;
  logic [63:0] a_q, acc_q;
  logic [31:0] b_q;
  logic [4:0]  cnt_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        enc_q;
  logic        q_ready_q, p_valid_q;
  logic [4:0]  p_rd_q;
  logic [31:0] p_data_q;

  logic [63:0] acc_d, a_d;
  logic [31:0] b_d;
  logic        last_step;
  logic [31:0] result;
  logic        dec_valid;

  // Bits of the instruction word and rs3 that play no part in the result.
  logic unused_bits;
  assign unused_bits = ^{q_rs3_i, q_instr_data_i[24:15]};

  assign dec_valid = (q_instr_data_i[6:0] == 7'b0110011) &&
                     (q_instr_data_i[31:25] == 7'b0000101);

  // One BUSY step: fold BitsPerCycle partial products into the accumulator.
  always_comb begin
    acc_d = acc_q;
    for (int j = 0; j < int'(BitsPerCycle); j++) begin
      if (b_q[j]) acc_d = acc_d ^ (a_q << j);
    end
    a_d = a_q << BitsPerCycle;
    b_d = b_q >> BitsPerCycle;
`ifdef ACC_CLMUL_EARLY_EXIT_EN
    last_step = (cnt_q == LAST) || (b_d == 32'd0);
`else
    last_step = (cnt_q == LAST);
`endif
  end

  // Result selection uses acc_d so the final step's partial products count.
  always_comb begin
    result = 32'd0;
    if (enc_q) begin
      unique case (f3_q)
        3'b001:  result = acc_d[31:0];
        3'b011:  result = acc_d[63:32];
        3'b010:  result = acc_d[62:31];
        default: result = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      enc_q     <= 1'b0;
      q_ready_q <= 1'b1;
      p_valid_q <= 1'b0;
      p_rd_q    <= '0;
      p_data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (q_valid_i) begin
            a_q       <= {32'd0, q_rs1_i};
            b_q       <= q_rs2_i;
            f3_q      <= q_instr_data_i[14:12];
            rd_q      <= q_instr_data_i[11:7];
            enc_q     <= dec_valid;
            acc_q     <= '0;
            cnt_q     <= '0;
            q_ready_q <= 1'b0;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          acc_q <= acc_d;
          a_q   <= a_d;
          b_q   <= b_d;
          cnt_q <= cnt_q + 5'd1;
          if (last_step) begin
            p_data_q  <= result;
            p_rd_q    <= rd_q;
            p_valid_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (p_ready_i) begin
            p_valid_q <= 1'b0;
            q_ready_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign q_ready_o = q_ready_q;
  assign p_valid_o = p_valid_q;
  assign p_rd_o    = p_rd_q;
  assign p_data_o  = p_data_q;

endmodule
